// File: rtl/falafel_rr_input_arbiter.sv
// Merges NUM_CH allocator request streams (size+id) into one request FIFO, round-robin or fixed priority.
// Latency: one registered output stage, so an accept at cycle t writes the FIFO at t+1 or later; 1 request/cycle.
// Backpressure: fifo_full_i holds a loaded stage stable and drops every req_rdy_o until full deasserts.
module falafel_rr_input_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int SIZE_W   = 16,
    parameter int ID_W     = 8,
    parameter int ARB_MODE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CH-1:0]              req_val_i,
    output logic [NUM_CH-1:0]              req_rdy_o,
    input  logic [NUM_CH-1:0][SIZE_W-1:0]  req_size_i,
    input  logic [NUM_CH-1:0][ID_W-1:0]    req_id_i,
    input  logic                           fifo_full_i,
    output logic                           fifo_write_o,
    output logic [SIZE_W-1:0]              fifo_din_size_o,
    output logic [ID_W-1:0]                fifo_din_id_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fifo_din_ch_o,
    input  logic                           clear_cnt_i,
    output logic [NUM_CH-1:0][CNT_W-1:0]   grant_cnt_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                          r_out_vld;
    logic [SIZE_W-1:0]             r_out_size;
    logic [ID_W-1:0]               r_out_id;
    logic [CH_W-1:0]               r_out_ch;
    logic [CH_W-1:0]               r_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;

    logic                          w_load_en;
    logic                          w_gnt_vld;
    logic                          w_accept;
    logic [NUM_CH-1:0]             w_gnt_oh;
    logic [CH_W-1:0]               w_gnt_ch;
    logic [CH_W-1:0]               w_ptr_nxt;
    logic [SIZE_W-1:0]             w_gnt_size;
    logic [ID_W-1:0]               w_gnt_id;
    int                            w_start;

    assign w_load_en = !r_out_vld || !fifo_full_i;
    assign w_start   = (ARB_MODE != 0) ? int'(r_ptr) : 0;

    // Scan positions start, start+1, ... (mod NUM_CH); the first valid channel found wins.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_oh   = '0;
        w_gnt_ch   = '0;
        w_gnt_size = '0;
        w_gnt_id   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_gnt_vld && req_val_i[i] && (i == (w_start + k) % NUM_CH)) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_oh[i] = 1'b1;
                    w_gnt_ch   = CH_W'(i);
                    w_gnt_size = req_size_i[i];
                    w_gnt_id   = req_id_i[i];
                end
            end
        end
    end

    assign w_accept  = w_load_en && w_gnt_vld;
    assign req_rdy_o = w_load_en ? w_gnt_oh : '0;
    assign w_ptr_nxt = CH_W'((int'(w_gnt_ch) + 1) % NUM_CH);

    assign fifo_write_o    = r_out_vld && !fifo_full_i;
    assign fifo_din_size_o = r_out_size;
    assign fifo_din_id_o   = r_out_id;
    assign fifo_din_ch_o   = r_out_ch;
    assign grant_cnt_o     = r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_out_vld  <= 1'b0;
            r_out_size <= '0;
            r_out_id   <= '0;
            r_out_ch   <= '0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_out_vld  <= 1'b1;
            r_out_size <= w_gnt_size;
            r_out_id   <= w_gnt_id;
            r_out_ch   <= w_gnt_ch;
            if (ARB_MODE != 0) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (fifo_write_o) begin
            r_out_vld <= 1'b0;
        end
    end

    // Clear takes priority over a same-cycle grant; counts stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_cnt_i) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept && (w_gnt_ch == CH_W'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule
